// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer: prescaled tick, one-shot or auto-reload
// count, sticky expiry flag and a level interrupt. Bus responder beside the
// LED/switch/button ports; reads are combinational for the single-cycle core.
module mmio_timer #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned PS_WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sel,
  input  logic             memWrite,
  input  logic             memRead,
  input  logic [WIDTH-1:0] dataAddress,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] readData,
  output logic             irq
);

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffLoad   = 3'd1;
  localparam logic [2:0] OffCount  = 3'd2;
  localparam logic [2:0] OffStatus = 3'd3;
  localparam logic [2:0] OffPs     = 3'd4;

  logic                enable_q, enable_d;
  logic                auto_q, auto_d;
  logic                irq_en_q, irq_en_d;
  logic                expired_q, expired_d;
  logic [WIDTH-1:0]    load_q, load_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [PS_WIDTH-1:0] prescale_q, prescale_d;
  logic [PS_WIDTH-1:0] ps_cnt_q, ps_cnt_d;

  logic [2:0] offset;
  logic       wr_en;
  logic       wr_ctrl, wr_load, wr_count, wr_status, wr_ps;
  logic       tick;
  logic       expire;

  // Only word offset bits take part in the decode.
  logic unused_addr;
  assign unused_addr = ^{dataAddress[WIDTH-1:6], dataAddress[2:0]};

  assign offset    = dataAddress[5:3];
  assign wr_en     = sel & memWrite;
  assign wr_ctrl   = wr_en && (offset == OffCtrl);
  assign wr_load   = wr_en && (offset == OffLoad);
  assign wr_count  = wr_en && (offset == OffCount);
  assign wr_status = wr_en && (offset == OffStatus);
  assign wr_ps     = wr_en && (offset == OffPs);

  assign tick   = enable_q && (ps_cnt_q == prescale_q);
  assign expire = tick && (count_q == '0);

  // Next-state for all registers; bus writes take priority over counting.
  always_comb begin
    enable_d   = enable_q;
    auto_d     = auto_q;
    irq_en_d   = irq_en_q;
    expired_d  = expired_q;
    load_d     = load_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    ps_cnt_d   = ps_cnt_q;

    // Prescaler: held at 0 when disabled, restarted on a 0->1 enable write.
    if (wr_ctrl && writeData[0] && !enable_q) begin
      ps_cnt_d = '0;
    end else if (!enable_q || tick) begin
      ps_cnt_d = '0;
    end else begin
      ps_cnt_d = ps_cnt_q + 1'b1;
    end

    // Counter: a COUNT write wins over a same-cycle decrement or reload.
    if (wr_count) begin
      count_d = writeData;
    end else if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else if (auto_q) begin
        count_d = load_q;
      end
    end

    // One-shot stops on expiry unless CTRL is written in the same cycle.
    if (wr_ctrl) begin
      enable_d = writeData[0];
      auto_d   = writeData[1];
      irq_en_d = writeData[2];
    end else if (expire && !auto_q) begin
      enable_d = 1'b0;
    end

    // Sticky flag: a new expiry beats a same-cycle W1C.
    if (expire) begin
      expired_d = 1'b1;
    end else if (wr_status && writeData[0]) begin
      expired_d = 1'b0;
    end

    if (wr_load) load_d = writeData;
    if (wr_ps)   prescale_d = writeData[PS_WIDTH-1:0];
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable_q   <= 1'b0;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      load_q     <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      ps_cnt_q   <= '0;
    end else begin
      enable_q   <= enable_d;
      auto_q     <= auto_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      ps_cnt_q   <= ps_cnt_d;
    end
  end

  // Combinational read mux; returns 0 unless a selected read is in progress.
  always_comb begin
    readData = '0;
    if (sel && memRead) begin
      unique case (offset)
        OffCtrl:   readData = WIDTH'({irq_en_q, auto_q, enable_q});
        OffLoad:   readData = load_q;
        OffCount:  readData = count_q;
        OffStatus: readData = WIDTH'(expired_q);
        OffPs:     readData = WIDTH'(prescale_q);
        default:   readData = '0;
      endcase
    end
  end

  assign irq = expired_q & irq_en_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: expected values are queued when a check is
// issued and popped when the DUT output is sampled mid-cycle.
module tb_mmio_timer;

  localparam int unsigned WIDTH    = 64;
  localparam int unsigned PS_WIDTH = 16;

  logic             clk;
  logic             resetn;
  logic             sel;
  logic             memWrite;
  logic             memRead;
  logic [WIDTH-1:0] dataAddress;
  logic [WIDTH-1:0] writeData;
  logic [WIDTH-1:0] readData;
  logic             irq;

  logic [WIDTH-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;

  mmio_timer #(
    .WIDTH   (WIDTH),
    .PS_WIDTH(PS_WIDTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sel        (sel),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .dataAddress(dataAddress),
    .writeData  (writeData),
    .readData   (readData),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] addr_of(input logic [2:0] off);
    return {58'd0, off, 3'd0};
  endfunction

  // Pop the oldest expectation and compare it against the sampled value.
  task automatic compare(input string tag, input logic [WIDTH-1:0] obs);
    logic [WIDTH-1:0] e;
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write commits on the following posedge.
  task automatic wr(input logic [2:0] off, input logic [WIDTH-1:0] d);
    sel         = 1'b1;
    memWrite    = 1'b1;
    dataAddress = addr_of(off);
    writeData   = d;
    @(negedge clk);
    sel      = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [WIDTH-1:0] e, input string tag);
    exp_q.push_back(e);
    sel         = 1'b1;
    memRead     = 1'b1;
    dataAddress = addr_of(off);
    #1;
    compare(tag, readData);
    sel     = 1'b0;
    memRead = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string tag);
    exp_q.push_back(WIDTH'(e));
    #1;
    compare(tag, WIDTH'(irq));
  endtask

  initial begin
    resetn      = 1'b0;
    sel         = 1'b0;
    memWrite    = 1'b0;
    memRead     = 1'b0;
    dataAddress = '0;
    writeData   = '0;
    #230;
    @(negedge clk);
    resetn = 1'b1;

    // Reset state
    for (int i = 0; i < 5; i++) rd(3'(i), 64'd0, "reset_reg");
    chk_irq(1'b0, "reset_irq");

    // One-shot: expiry exactly 4 cycles after the enabling write edge
    wr(3'd4, 64'd0);
    wr(3'd2, 64'd3);
    wr(3'd0, 64'd1);
    wait_cyc(3);
    rd(3'd3, 64'd0, "oneshot_not_yet");
    wait_cyc(1);
    rd(3'd3, 64'd1, "oneshot_expired");
    rd(3'd0, 64'd0, "oneshot_enable_off");
    rd(3'd2, 64'd0, "oneshot_count0");
    chk_irq(1'b0, "oneshot_irq_masked");
    wait_cyc(2);
    rd(3'd2, 64'd0, "oneshot_count_stays0");
    wr(3'd3, 64'd1);
    rd(3'd3, 64'd0, "w1c_clear");

    // Auto-reload with prescale 1: period (2+1)*(1+1) = 6
    wr(3'd4, 64'd1);
    wr(3'd1, 64'd2);
    wr(3'd2, 64'd2);
    wr(3'd0, 64'd7);
    wait_cyc(5);
    chk_irq(1'b0, "auto_irq_before");
    wait_cyc(1);
    chk_irq(1'b1, "auto_irq_first");
    rd(3'd2, 64'd2, "auto_reload_count1");
    wr(3'd3, 64'd1);
    chk_irq(1'b0, "auto_irq_cleared");
    wait_cyc(4);
    chk_irq(1'b0, "auto_irq_before2");
    wait_cyc(1);
    chk_irq(1'b1, "auto_irq_second");
    rd(3'd2, 64'd2, "auto_reload_count2");
    wait_cyc(5);
    // W1C lands on the next expiry edge: set must win
    wr(3'd3, 64'd1);
    rd(3'd3, 64'd1, "collide_w1c_expiry");
    chk_irq(1'b1, "collide_irq");
    wr(3'd0, 64'd0);
    wr(3'd3, 64'd1);
    rd(3'd3, 64'd0, "collide_cleared");

    // COUNT write on a tick cycle wins over the decrement
    wr(3'd4, 64'd0);
    wr(3'd2, 64'd5);
    wr(3'd0, 64'd1);
    wr(3'd2, 64'd10);
    rd(3'd2, 64'd10, "collide_count_write");
    wr(3'd0, 64'd0);
    rd(3'd2, 64'd9, "count_decrement");

    // Bus decode
    wr(3'd3, 64'd1);
    wr(3'd1, 64'h55);
    wr(3'd2, 64'h33);
    wr(3'd4, 64'h7);
    wr(3'd0, 64'hFE);
    wr(3'd6, 64'hFF);
    rd(3'd0, 64'h6, "dec_ctrl");
    rd(3'd1, 64'h55, "dec_load");
    rd(3'd2, 64'h33, "dec_count");
    rd(3'd3, 64'h0, "dec_status");
    rd(3'd4, 64'h7, "dec_prescale");
    rd(3'd6, 64'h0, "dec_off6");
    wr(3'd4, 64'h12345);
    rd(3'd4, 64'h2345, "prescale_trunc");

    sel         = 1'b0;
    memWrite    = 1'b1;
    dataAddress = addr_of(3'd1);
    writeData   = 64'h77;
    @(negedge clk);
    memWrite = 1'b0;
    rd(3'd1, 64'h55, "nosel_write");

    exp_q.push_back(64'd0);
    sel         = 1'b1;
    memRead     = 1'b0;
    dataAddress = addr_of(3'd1);
    #1;
    compare("no_memread", readData);
    sel = 1'b0;

    @(negedge clk);
    exp_q.push_back(64'h55);
    sel         = 1'b1;
    memRead     = 1'b1;
    memWrite    = 1'b1;
    dataAddress = addr_of(3'd1);
    writeData   = 64'h99;
    #1;
    compare("rdwr_old_value", readData);
    @(negedge clk);
    sel      = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    rd(3'd1, 64'h99, "rdwr_new_value");

    // Reset mid-count aborts immediately without expiry
    wr(3'd4, 64'd0);
    wr(3'd2, 64'd100);
    wr(3'd0, 64'd5);
    wait_cyc(3);
    rd(3'd2, 64'd97, "midcount_running");
    resetn = 1'b0;
    #1;
    rd(3'd2, 64'd0, "midreset_count");
    rd(3'd0, 64'd0, "midreset_ctrl");
    chk_irq(1'b0, "midreset_irq");
    @(negedge clk);
    resetn = 1'b1;
    wait_cyc(2);
    rd(3'd2, 64'd0, "postreset_count");
    rd(3'd3, 64'd0, "postreset_status");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
